mips_data_bus_bridge: RTL and testbench
=======================================

Name: mips_data_bus_bridge

Overview:
Bridges the CPU's single-cycle Harvard data port to a waitrequest-style data memory bus. The CPU's core sits upstream; the data RAM or bus fabric sits downstream.
- Registers each CPU load/store and holds the CPU with a stall until the bus completes it.
- Optionally byte-swaps data between CPU word order and memory byte order.
- Guards against a hung bus with a timeout that sets a sticky error flag.

Parameters:
SWAP_BYTES, 1, when 1 reverse byte order of writedata, readdata and byteenable; when 0 pass through unchanged
TIMEOUT_CYCLES, 256, bus cycles with waitrequest high before an access is aborted; 0 disables timeout; legal range 0..65535

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; asserted at 0
cpu_data_address  input  32  byte address from CPU
cpu_data_read  input  1  CPU load request
cpu_data_write  input  1  CPU store request
cpu_data_writedata  input  32  store data, CPU byte order
cpu_byteenable  input  4  store byte lanes, CPU order
cpu_data_readdata  output  32  load result, CPU byte order
cpu_stall  output  1  CPU must hold PC and request while high
bus_error  output  1  sticky, set on timeout abort
mem_address  output  32  word-aligned address {addr[31:2],2'b00}
mem_read  output  1  bus read strobe
mem_write  output  1  bus write strobe
mem_writedata  output  32  store data, memory order
mem_byteenable  output  4  byte lanes, memory order; 4'b1111 on reads
mem_waitrequest  input  1  bus not ready; strobes and address must be held while high
mem_readdata  input  32  read data, valid in a cycle where mem_read=1 and mem_waitrequest=0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; timeout counter=0; bus_error=0; captured read data=0.
  - All mem_* outputs are 0 and cpu_stall is 0 immediately, not at the next edge.
  - An in-flight access is dropped with no bus completion owed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - A request (cpu_data_read or cpu_data_write) drives cpu_stall=1 combinationally in the same cycle.
  - The same cycle latches address, writedata, byteenable and op; next state is ACCESS.
  - If read and write are both high, write wins and the read is ignored.
  - With no request: cpu_stall=0, no bus activity.
- ACCESS:
  - mem_read or mem_write=1, driven only from the latched registers; cpu_stall=1.
  - Edge with mem_waitrequest=0: capture mem_readdata (reads only); go to DONE; reset the counter.
  - Edge with mem_waitrequest=1: counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: drop strobes, set bus_error, load captured data=32'h0, go to DONE.
- DONE:
  - cpu_stall=0; strobes are 0; cpu_data_readdata = captured data; next state is always IDLE.
  - The request still presented by the CPU in DONE is the one just completed and must not restart.
- cpu_data_readdata holds its last captured value in all states except reset.
- Latency:
  - Zero-wait access: request seen in cycle 0; bus strobe in cycle 1; stall low in cycle 2.
  - Total stall is 2 cycles, plus 1 per waitrequest-high cycle.
- Byte swap: with SWAP_BYTES=1:
  - mem_writedata = {wd[7:0],wd[15:8],wd[23:16],wd[31:24]}; readdata is treated the same way.
  - mem_byteenable = {be[0],be[1],be[2],be[3]}.
- bus_error clears only on reset.
- Back-to-back requests: a new request in the cycle after DONE is accepted normally (IDLE→ACCESS).

Test Plan:
- Zero-wait read: read at 0x00001004, mem_readdata=32'h11223344, waitrequest=0, SWAP_BYTES=1 -> mem_address=0x00001004, mem_read high exactly 1 cycle, cpu_stall high 2 cycles, cpu_data_readdata=32'h44332211 in DONE.
- Waited write: write at 0x00002002, writedata=32'hAABBCCDD, be=4'b0011, waitrequest high 3 cycles -> mem_writedata=32'hDDCCBBAA and mem_byteenable=4'b1100, both held stable 4 cycles; cpu_stall high 5 cycles; a single write on the bus.
- Simultaneous read+write: both high at 0x10 -> only mem_write issued, mem_read never asserted.
- Timeout: TIMEOUT_CYCLES=4, waitrequest stuck high -> strobes drop after 4 wait edges, bus_error=1 and stays 1 across later good accesses, readdata=0.
- Async reset mid-ACCESS: reset=0 between clock edges while mem_read=1 -> mem_read, cpu_stall, bus_error go 0 immediately; after release, a fresh read completes normally.
- Back-to-back: read then write on consecutive CPU instructions with waitrequest=0 -> two bus transactions, no duplicated read, stall pattern 1,1,0,1,1,0.

Source files
------------

// File: rtl/mips_data_bus_bridge.sv
// Bridges the CPU's single-cycle data port to a waitrequest-style memory bus.
// Holds the CPU with a stall until the access completes, with optional byte swap and a timeout.
module mips_data_bus_bridge #(
  parameter bit          SWAP_BYTES     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_stall,
  output logic        bus_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wrData_q;
  logic [3:0]  byteEn_q;
  logic        read_q;
  logic        write_q;
  logic [31:0] rdData_q;
  logic [15:0] count_q;
  logic        error_q;

  logic        cpuReq;
  logic [15:0] count_d;
  logic        unusedAddrBits;

  function automatic logic [31:0] swapWord(input logic [31:0] w);
    return SWAP_BYTES ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  function automatic logic [3:0] swapLanes(input logic [3:0] b);
    return SWAP_BYTES ? {b[0], b[1], b[2], b[3]} : b;
  endfunction

  assign cpuReq         = cpu_data_read | cpu_data_write;
  assign count_d        = count_q + 16'd1;
  assign unusedAddrBits = ^cpu_data_address[1:0];

  // Strobes come straight from registers, so they only ever reflect the latched request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wrData_q <= '0;
      byteEn_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      rdData_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpuReq) begin
            addr_q   <= {cpu_data_address[31:2], 2'b00};
            wrData_q <= swapWord(cpu_data_writedata);
            byteEn_q <= cpu_data_write ? swapLanes(cpu_byteenable) : 4'b1111;
            write_q  <= cpu_data_write;
            read_q   <= ~cpu_data_write;
            count_q  <= '0;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_waitrequest) begin
            if (read_q) begin
              rdData_q <= swapWord(mem_readdata);
            end
            read_q  <= 1'b0;
            write_q <= 1'b0;
            count_q <= '0;
            state_q <= DONE;
          end else if (TIMEOUT_EN && (count_d == TIMEOUT_LIMIT)) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            error_q  <= 1'b1;
            rdData_q <= '0;
            count_q  <= '0;
            state_q  <= DONE;
          end else begin
            count_q <= count_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The stall is gated by reset so it drops the instant reset asserts, even with a request pending.
  assign cpu_stall         = reset & ((state_q == ACCESS) | ((state_q == IDLE) & cpuReq));
  assign cpu_data_readdata = rdData_q;
  assign bus_error         = error_q;
  assign mem_address       = addr_q;
  assign mem_read          = read_q;
  assign mem_write         = write_q;
  assign mem_writedata     = wrData_q;
  assign mem_byteenable    = byteEn_q;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Scoreboard bench for mips_data_bus_bridge: directed accesses push expectations,
// a negedge monitor pops and compares bus transactions and CPU completions.
module tb_mips_data_bus_bridge;

  typedef struct {
    logic [31:0] addr;
    logic        isWrite;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          strobes;
    logic        completed;
  } busExp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } cpuExp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_data_address = '0;
  logic        cpu_data_read = 1'b0;
  logic        cpu_data_write = 1'b0;
  logic [31:0] cpu_data_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic [31:0] cpu_data_readdata;
  logic        cpu_stall;
  logic        bus_error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;

  busExp_t busQ[$];
  cpuExp_t cpuQ[$];
  int      vectors = 0;
  int      miscompares = 0;
  int      waitLeft = 0;
  int      strobeCnt = 0;
  int      stallCnt = 0;
  logic    lastWait = 1'b0;

  mips_data_bus_bridge #(.SWAP_BYTES(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_byteenable(cpu_byteenable), .cpu_data_readdata(cpu_data_readdata),
    .cpu_stall(cpu_stall), .bus_error(bus_error),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus model: holds waitrequest high for waitLeft strobe cycles, then completes.
  always @(posedge clk) begin
    #2;
    if (mem_read || mem_write) begin
      if (waitLeft > 0) begin
        mem_waitrequest = 1'b1;
        waitLeft--;
      end else begin
        mem_waitrequest = 1'b0;
      end
    end else begin
      mem_waitrequest = 1'b0;
    end
  end

  // Monitor: per-cycle bus checks, plus end-of-transaction and end-of-stall scoreboard pops.
  always @(negedge clk) begin
    busExp_t b;
    cpuExp_t c;
    if (!reset) begin
      strobeCnt = 0;
      stallCnt  = 0;
      busQ.delete();
      cpuQ.delete();
    end else begin
      if (mem_read || mem_write) begin
        if (busQ.size() == 0) begin
          checkOutput("unexpectedStrobe", {30'd0, mem_read, mem_write}, 32'd0);
        end else begin
          checkOutput("busAddr", mem_address, busQ[0].addr);
          checkOutput("busWrite", {31'd0, mem_write}, {31'd0, busQ[0].isWrite});
          checkOutput("busRead", {31'd0, mem_read}, {31'd0, ~busQ[0].isWrite});
          checkOutput("busBe", {28'd0, mem_byteenable}, {28'd0, busQ[0].be});
          if (busQ[0].isWrite) checkOutput("busWdata", mem_writedata, busQ[0].wdata);
        end
        strobeCnt++;
        lastWait = mem_waitrequest;
      end else if (strobeCnt > 0) begin
        if (busQ.size() == 0) begin
          checkOutput("busQueueEmpty", 32'd0, 32'd1);
        end else begin
          b = busQ.pop_front();
          checkOutput("strobeCycles", strobeCnt, b.strobes);
          checkOutput("busCompleted", {31'd0, ~lastWait}, {31'd0, b.completed});
        end
        strobeCnt = 0;
      end
      if (cpu_stall) begin
        stallCnt++;
      end else if (stallCnt > 0) begin
        if (cpuQ.size() == 0) begin
          checkOutput("cpuQueueEmpty", 32'd0, 32'd1);
        end else begin
          c = cpuQ.pop_front();
          checkOutput("stallCycles", stallCnt, c.stalls);
          checkOutput("readData", cpu_data_readdata, c.rdata);
          checkOutput("busError", {31'd0, bus_error}, {31'd0, c.err});
        end
        stallCnt = 0;
      end
    end
  end

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] be, input int nWait,
                               input logic [31:0] memRd, input busExp_t b, input cpuExp_t c);
    int n;
    busQ.push_back(b);
    cpuQ.push_back(c);
    waitLeft           = nWait;
    mem_readdata       = memRd;
    cpu_data_address   = addr;
    cpu_data_writedata = wd;
    cpu_byteenable     = be;
    cpu_data_read      = rd;
    cpu_data_write     = wr;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cpu_stall && n < 100);
    if (cpu_stall) checkOutput("stallBound", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    checkOutput("rstStall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rstMemRead", {31'd0, mem_read}, 32'd0);
    checkOutput("rstMemWrite", {31'd0, mem_write}, 32'd0);
    checkOutput("rstBusError", {31'd0, bus_error}, 32'd0);
    checkOutput("rstReadData", cpu_data_readdata, 32'd0);
    checkOutput("rstMemAddr", mem_address, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycles(1);

    // Zero-wait read, partial byteenable must become 4'b1111 on the bus.
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'b0101, 0, 32'h1122_3344,
                  '{32'h0000_1004, 1'b0, 32'h0, 4'b1111, 1, 1'b1},
                  '{32'h4433_2211, 1'b0, 2});
    idleCycles(1);

    // Write with three waitrequest cycles, unaligned address.
    applyStimulus(1'b0, 1'b1, 32'h0000_2002, 32'hAABB_CCDD, 4'b0011, 3, 32'h0,
                  '{32'h0000_2000, 1'b1, 32'hDDCC_BBAA, 4'b1100, 4, 1'b1},
                  '{32'h4433_2211, 1'b0, 5});
    idleCycles(1);

    // Read and write together: write wins.
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 0, 32'hDEAD_BEEF,
                  '{32'h0000_0010, 1'b1, 32'h7856_3412, 4'b1111, 1, 1'b1},
                  '{32'h4433_2211, 1'b0, 2});
    idleCycles(1);

    // Back-to-back read then write.
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b1111, 0, 32'hA1B2_C3D4,
                  '{32'h0000_0020, 1'b0, 32'h0, 4'b1111, 1, 1'b1},
                  '{32'hD4C3_B2A1, 1'b0, 2});
    applyStimulus(1'b0, 1'b1, 32'h0000_0024, 32'h0102_0304, 4'b1000, 0, 32'h0,
                  '{32'h0000_0024, 1'b1, 32'h0403_0201, 4'b0001, 1, 1'b1},
                  '{32'hD4C3_B2A1, 1'b0, 2});
    idleCycles(1);

    // Hung bus: abort after four wait edges.
    applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'b1111, 1000, 32'hFFFF_FFFF,
                  '{32'h0000_0030, 1'b0, 32'h0, 4'b1111, 4, 1'b0},
                  '{32'h0000_0000, 1'b1, 5});
    waitLeft = 0;
    idleCycles(1);

    // Good read afterwards: error stays sticky.
    applyStimulus(1'b1, 1'b0, 32'h0000_0034, 32'h0, 4'b1111, 1, 32'h0A0B_0C0D,
                  '{32'h0000_0034, 1'b0, 32'h0, 4'b1111, 2, 1'b1},
                  '{32'h0D0C_0B0A, 1'b1, 3});
    idleCycles(1);

    // Asynchronous reset in the middle of an access.
    waitLeft         = 10;
    cpu_data_address = 32'h0000_0040;
    cpu_data_read    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("preResetRead", {31'd0, mem_read}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncMemRead", {31'd0, mem_read}, 32'd0);
    checkOutput("asyncStall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("asyncBusError", {31'd0, bus_error}, 32'd0);
    checkOutput("asyncReadData", cpu_data_readdata, 32'd0);
    cpu_data_read = 1'b0;
    waitLeft      = 0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    idleCycles(1);

    // Fresh read after reset release.
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b1111, 0, 32'hCAFE_F00D,
                  '{32'h0000_0044, 1'b0, 32'h0, 4'b1111, 1, 1'b1},
                  '{32'h0DF0_FECA, 1'b0, 2});
    idleCycles(3);

    checkOutput("busQueueDrained", busQ.size(), 32'd0);
    checkOutput("cpuQueueDrained", cpuQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
